// File: rtl/dmi_cdc_bridge.sv
// dmi_cdc_bridge: clk-domain side of the DMI toggle handshake.
// Optional abort timer enabled by DMI_BRIDGE_TIMEOUT_EN.
module dmi_cdc_bridge #(
  parameter int ABITS          = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dmi_start,
  output logic             dmi_finish,
  input  logic [1:0]       dmi_op,
  input  logic [ABITS-1:0] dmi_address,
  input  logic [31:0]      dmi_wdata,
  output logic [31:0]      dmi_rdata,
  output logic             dm_req_valid,
  input  logic             dm_req_ready,
  output logic             dm_req_we,
  output logic [ABITS-1:0] dm_req_addr,
  output logic [31:0]      dm_req_wdata,
  input  logic             dm_rsp_valid,
  input  logic [31:0]      dm_rsp_rdata,
  output logic             dmi_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP
  } state_t;

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_INIT = WW'(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("dmi_cdc_bridge: SYNC_STAGES must be 2..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("dmi_cdc_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [WW-1:0]          r_warm;
  logic                   r_seen;
  logic                   w_seen_nxt;
  logic                   w_sync_out;
  logic                   w_warm;
  logic                   w_pending;

  logic             r_finish;
  logic [31:0]      r_rdata;
  logic             r_req_valid;
  logic             r_req_we;
  logic [ABITS-1:0] r_req_addr;
  logic [31:0]      r_req_wdata;
  logic             r_timeout;

  logic             w_finish_nxt;
  logic [31:0]      w_rdata_nxt;
  logic             w_req_valid_nxt;
  logic             w_req_we_nxt;
  logic [ABITS-1:0] w_req_addr_nxt;
  logic [31:0]      w_req_wdata_nxt;
  logic             w_timeout_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_warm     = (r_warm != '0);
  assign w_pending  = !w_warm && (w_sync_out != r_seen);

  // Bring the tclk-domain toggle into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], dmi_start};
    end
  end

  // Hold off requests until the synchroniser has flushed after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm <= WARM_INIT;
    end else if (w_warm) begin
      r_warm <= r_warm - WW'(1);
    end
  end

`ifdef DMI_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Cycles spent on the current DM access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  // Next-state and next-output logic for the access FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_seen_nxt      = r_seen;
    w_finish_nxt    = r_finish;
    w_rdata_nxt     = r_rdata;
    w_req_valid_nxt = r_req_valid;
    w_req_we_nxt    = r_req_we;
    w_req_addr_nxt  = r_req_addr;
    w_req_wdata_nxt = r_req_wdata;
    w_timeout_nxt   = r_timeout;
`ifdef DMI_BRIDGE_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif

    if (w_warm) begin
      w_seen_nxt = w_sync_out;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_seen_nxt      = w_sync_out;
          w_req_we_nxt    = (dmi_op == 2'd2);
          w_req_addr_nxt  = dmi_address;
          w_req_wdata_nxt = dmi_wdata;
`ifdef DMI_BRIDGE_TIMEOUT_EN
          w_timeout_nxt   = 1'b0;
          w_cnt_nxt       = '0;
`endif
          if (dmi_op == 2'd1 || dmi_op == 2'd2) begin
            w_req_valid_nxt = 1'b1;
            w_state_nxt     = S_REQ;
          end else begin
            w_finish_nxt = ~r_finish;
          end
        end
      end
      S_REQ: begin
        if (r_req_valid && dm_req_ready) begin
          w_req_valid_nxt = 1'b0;
          w_state_nxt     = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (dm_rsp_valid) begin
          if (!r_req_we) begin
            w_rdata_nxt = dm_rsp_rdata;
          end
          w_finish_nxt = ~r_finish;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_req_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase

`ifdef DMI_BRIDGE_TIMEOUT_EN
    if (r_state == S_REQ || r_state == S_WAIT_RSP) begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (w_state_nxt != S_IDLE && r_cnt == TMO_LAST) begin
        w_req_valid_nxt = 1'b0;
        w_rdata_nxt     = '0;
        w_timeout_nxt   = 1'b1;
        w_finish_nxt    = ~r_finish;
        w_state_nxt     = S_IDLE;
      end
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seen      <= 1'b0;
      r_finish    <= 1'b0;
      r_rdata     <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seen      <= w_seen_nxt;
      r_finish    <= w_finish_nxt;
      r_rdata     <= w_rdata_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_we    <= w_req_we_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign dmi_finish   = r_finish;
  assign dmi_rdata    = r_rdata;
  assign dm_req_valid = r_req_valid;
  assign dm_req_we    = r_req_we;
  assign dm_req_addr  = r_req_addr;
  assign dm_req_wdata = r_req_wdata;
  assign dmi_timeout  = r_timeout;

endmodule

// File: doc/dmi_cdc_bridge.md
Name: dmi_cdc_bridge

Overview:
- System-clock side of the debug transport. Consumes the toggle-handshake DMI request from the JTAG DTM (tclk domain) and synchronises it into clk.
- Issues one valid/ready access to the debug module, waits for the response, then returns read data and a finish toggle to the DTM.
- Sits between the DTM's DMI trivial bus and the debug module register file.

Parameters:
- ABITS, 7, DMI address width; equals DTM abits.
- SYNC_STAGES, 2, flops in the dmi_start synchroniser; legal values 2..4.
- TIMEOUT_CYCLES, 1024, clk cycles before an unanswered access is aborted (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- dmi_start  in  1  request toggle from the DTM (tclk domain, asynchronous to clk).
- dmi_finish  out  1  completion toggle to the DTM.
- dmi_op  in  2  1=read, 2=write; quasi-static while the request is in flight.
- dmi_address  in  ABITS  quasi-static.
- dmi_wdata  in  32  connects to DTM dmi_data_o; quasi-static.
- dmi_rdata  out  32  connects to DTM dmi_data_i.
- dm_req_valid  out  1  request to the debug module.
- dm_req_ready  in  1  debug module accepts the request.
- dm_req_we  out  1  1 = write.
- dm_req_addr  out  ABITS  request address.
- dm_req_wdata  out  32  request write data.
- dm_rsp_valid  in  1  single-cycle response strobe.
- dm_rsp_rdata  in  32  response data, valid with dm_rsp_valid.
- dmi_timeout  out  1  sticky abort flag; tied 0 without the optional feature.

Behaviour:
- Reset values: dmi_finish=0, dmi_rdata=0, dm_req_valid=0, dm_req_we=0, dm_req_addr=0, dm_req_wdata=0, dmi_timeout=0, state=IDLE, synchroniser=0, seen=0.
- Synchroniser: SYNC_STAGES flops on dmi_start; sync_out is the last stage.
- Register seen holds the last dmi_start level already serviced. A request is pending when sync_out != seen.
- Warm-up: for SYNC_STAGES+1 cycles after rst_n deasserts, seen <= sync_out every cycle and no request is accepted. This prevents a spurious access when the DTM was not reset and dmi_start is already 1.
- FSM states IDLE, REQ, WAIT_RSP.
- IDLE:
  - If pending: seen <= sync_out; capture dmi_op/dmi_address/dmi_wdata into dm_req_we/dm_req_addr/dm_req_wdata; clear dmi_timeout (feature on).
  - If op is 1 or 2: dm_req_valid <= 1, go to REQ.
  - If op is 0 or 3: no DM access; toggle dmi_finish on the next edge; dmi_rdata unchanged; stay in IDLE.
- Latency: dm_req_valid rises on the (SYNC_STAGES+1)th rising clk edge after the dmi_start toggle is first sampled.
- REQ: hold dm_req_* stable while dm_req_valid=1. On dm_req_valid && dm_req_ready: dm_req_valid <= 0, go to WAIT_RSP. dm_rsp_valid seen in REQ is ignored.
- WAIT_RSP: on dm_rsp_valid, on the same edge: dmi_rdata <= dm_rsp_rdata for reads (unchanged for writes), dmi_finish <= ~dmi_finish, go to IDLE.
- dmi_rdata changes only on a finish toggle edge, so it is stable for the DTM's tclk-domain sampling.
- A new dmi_start toggle arriving while busy is not lost: it stays pending until IDLE.
- Two toggles arriving while busy cancel and are not serviced. This is legal because the DTM never issues a second request before the finish.
- A DTM dmihardreset mid-access does not affect this block. The access completes and the finish toggle is harmlessly ignored by the DTM FSM.
- rst_n asserted mid-access: immediate return to reset values; any outstanding DM response is dropped.

Optional Feature:
- Macro DMI_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
  - Reaching TIMEOUT_CYCLES-1 without completion: dm_req_valid <= 0, dmi_rdata <= 0, dmi_timeout <= 1, dmi_finish toggles, go to IDLE.
  - A later dm_rsp_valid from the aborted access is ignored.
- Undefined: no counter; the bridge waits indefinitely; dmi_timeout is constant 0.

Test Plan:
- Write: after reset and warm-up, set op=2, addr=0x10, wdata=0xCAFEF00D, then toggle dmi_start 0->1 -> dm_req_valid high with we=1, addr=0x10, wdata=0xCAFEF00D, exactly 3 clks after sampling (SYNC_STAGES=2); hold dm_req_ready 0 for 5 clks -> fields stable; ready then rsp -> dmi_finish 0->1.
- Read: op=1, addr=0x11, dm_rsp_rdata=0x12345678 -> dmi_rdata=0x12345678 on the edge dmi_finish toggles; value held through the next write.
- Null op: op=0, toggle dmi_start -> no dm_req_valid; dmi_finish toggles; dmi_rdata unchanged.
- Warm-up: release rst_n with dmi_start already 1 -> no dm_req_valid within 20 clks; a subsequent toggle to 0 -> one access.
- Back-to-back: toggle dmi_start again just after the first finish -> second access issued, none lost or duplicated; also assert rst_n mid WAIT_RSP -> all outputs return to reset values and the late rsp is ignored.
- With DMI_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16: never assert ready -> at cycle 16 dm_req_valid drops, dmi_timeout=1, dmi_rdata=0, finish toggles; next accepted request clears dmi_timeout.
